// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// Write-through bypass and allocation tracking for out-of-order issue.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_R0    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
  output logic [NREAD*DATA_WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]             rbusy,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         alloc_ok,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int AW   = ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  assign alloc_ok = !busy_q[alloc_addr] ||
                    (ZERO_R0 != 0 && alloc_addr == '0);
  assign busy_cnt = cnt_q;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    cnt_d  = '0;
    // later ports overwrite earlier ones: highest port wins
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j]) begin
        regs_d[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
        busy_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && alloc_ok)
      busy_d[alloc_addr] = 1'b1;
    if (ZERO_R0 != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
    for (int k = 0; k < NREG; k++)
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[k]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++)
        regs_q[k] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b;

    assign a = raddr[i*AW +: AW];

    always_comb begin
      d = regs_q[a];
      b = busy_q[a];
      // bypass gated by reset so reads stay zero while held in reset
      if (BYPASS != 0 && rst_n) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (we[j] && waddr[j*AW +: AW] == a) begin
            d = wdata[j*DW +: DW];
            b = 1'b0;
          end
        end
      end
      if (ZERO_R0 != 0 && a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rdata[i*DW +: DW] = d;
    assign rbusy[i]          = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp.
// Table of per-cycle stimulus plus hand-written reset sequences.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_ok;
  logic [5:0]  busy_cnt;

  int errors = 0;
  int checks = 0;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .alloc_ok(alloc_ok), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        al_en;
    logic [4:0]  al_a;
    logic [31:0] e_rd0;
    logic        e_rb0;
    logic [31:0] e_rd1;
    logic        e_aok;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  initial begin
    //        we     wa0 wd0           wa1 wd1    ra0 ra1 al al_a rd0           rb0 rd1           aok cnt
    vec[0]  = '{2'b01, 3, 32'hDEADBEEF, 0, 0,     3,  3,  0, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 0};
    vec[1]  = '{2'b00, 0, 0,            0, 0,     3,  5,  0, 0,  32'hDEADBEEF, 0, 0,            1, 0};
    vec[2]  = '{2'b11, 5, 32'h11,       5, 32'h22, 5, 3,  0, 0,  32'h22,       0, 32'hDEADBEEF, 1, 0};
    vec[3]  = '{2'b00, 0, 0,            0, 0,     5,  5,  0, 0,  32'h22,       0, 32'h22,       1, 0};
    vec[4]  = '{2'b01, 0, 32'h55,       0, 0,     0,  0,  0, 0,  0,            0, 0,            1, 0};
    vec[5]  = '{2'b00, 0, 0,            0, 0,     0,  0,  1, 0,  0,            0, 0,            1, 0};
    vec[6]  = '{2'b00, 0, 0,            0, 0,     7,  5,  1, 7,  0,            0, 32'h22,       1, 1};
    vec[7]  = '{2'b00, 0, 0,            0, 0,     7,  5,  1, 7,  0,            1, 32'h22,       0, 1};
    vec[8]  = '{2'b10, 0, 0,            7, 32'h77, 7, 5,  0, 7,  32'h77,       0, 32'h22,       0, 0};
    vec[9]  = '{2'b00, 0, 0,            0, 0,     7,  7,  0, 7,  32'h77,       0, 32'h77,       1, 0};
    vec[10] = '{2'b01, 9, 32'h99,       0, 0,     9,  7,  1, 9,  32'h99,       0, 32'h77,       1, 1};
    vec[11] = '{2'b00, 0, 0,            0, 0,     9,  7,  0, 9,  32'h99,       1, 32'h77,       0, 1};
    vec[12] = '{2'b01, 9, 32'hAA,       0, 0,     9,  12, 1, 12, 32'hAA,       0, 0,            1, 1};
    vec[13] = '{2'b11, 12, 32'h1,       12, 32'h2, 12, 9, 1, 20, 32'h2,        0, 32'hAA,       1, 1};
    vec[14] = '{2'b00, 0, 0,            0, 0,     20, 12, 0, 20, 0,            1, 32'h2,        0, 1};

    rst_n = 1'b0;
    raddr = '0;
    idle();
    #1;
    chk("reset_cnt", busy_cnt, 0);
    chk("reset_aok", alloc_ok, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vec[i]) begin
      @(negedge clk);
      we         = vec[i].we;
      waddr      = {vec[i].wa1, vec[i].wa0};
      wdata      = {vec[i].wd1, vec[i].wd0};
      raddr      = {vec[i].ra1, vec[i].ra0};
      alloc_en   = vec[i].al_en;
      alloc_addr = vec[i].al_a;
      #1;
      chk($sformatf("v%0d_rdata0", i), rdata[31:0], vec[i].e_rd0);
      chk($sformatf("v%0d_rbusy0", i), rbusy[0], vec[i].e_rb0);
      chk($sformatf("v%0d_rdata1", i), rdata[63:32], vec[i].e_rd1);
      chk($sformatf("v%0d_aok", i), alloc_ok, vec[i].e_aok);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), busy_cnt, vec[i].e_cnt);
    end

    // asynchronous reset mid-cycle, with a write held on the bus
    @(negedge clk);
    idle();
    raddr = {5'd9, 5'd3};
    alloc_addr = 5'd20;
    #1;
    chk("pre_rst_rd0", rdata[31:0], 32'hDEADBEEF);
    #2;
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h1234};
    rst_n = 1'b0;
    #1;
    chk("arst_rd0", rdata[31:0], 0);
    chk("arst_rd1", rdata[63:32], 0);
    chk("arst_cnt", busy_cnt, 0);
    chk("arst_aok", alloc_ok, 1);
    raddr = {5'd9, 5'd20};
    #1;
    chk("arst_rbusy", rbusy, 0);

    // edge during reset must not write or allocate
    alloc_en = 1'b1;
    alloc_addr = 5'd4;
    @(posedge clk);
    #1;
    chk("rst_edge_cnt", busy_cnt, 0);
    @(negedge clk);
    idle();
    raddr = {5'd4, 5'd3};
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd0", rdata[31:0], 0);
    chk("post_rst_rbusy1", rbusy[1], 0);
    @(posedge clk);
    #1;
    chk("post_rst_cnt", busy_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_WIDTH, 5, register index width, NREG = 2**ADDR_WIDTH.
REQ-002 DATA_WIDTH, 32, register data width.
REQ-003 NREAD, 2, number of read ports, range 1..4.
REQ-004 NWRITE, 2, number of write ports, range 1..4.
REQ-005 BYPASS, 1, 1 = same-cycle write data is forwarded to read ports, 0 = reads show stored value only.
REQ-006 ZERO_R0, 1, 1 = register 0 is hard-wired to zero and is never busy.
REQ-007 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock; all state updates on its rising edge.
REQ-008 rst_n, in, 1, asynchronous active-low reset.
REQ-009 raddr, in, NREAD*ADDR_WIDTH, read addresses; port i occupies slice i.
REQ-010 rdata, out, NREAD*DATA_WIDTH, combinational read data per port.
REQ-011 rbusy, out, NREAD, combinational busy (pending-write) flag per read port.
REQ-012 we, in, NWRITE, write enables.
REQ-013 waddr, in, NWRITE*ADDR_WIDTH, write addresses.
REQ-014 wdata, in, NWRITE*DATA_WIDTH, write data.
REQ-015 alloc_en, in, 1, request to mark alloc_addr as pending.
REQ-016 alloc_addr, in, ADDR_WIDTH, register to mark pending.
REQ-017 alloc_ok, out, 1, combinational: allocation of alloc_addr is accepted this cycle.
REQ-018 busy_cnt, out, ADDR_WIDTH+1, registered count of busy registers.

Function
REQ-019 Storage SHALL be NREG x DATA_WIDTH registers plus an NREG-bit busy vector.
REQ-020 A write on port j with we[j]=1 SHALL update the register at waddr[j] at the next rising edge; write latency is 1 cycle.
REQ-021 When several enabled write ports target the same address in one cycle, the highest-numbered port SHALL win.
REQ-022 With ZERO_R0=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 with rbusy=0.
REQ-023 rdata[i] SHALL show the stored value of raddr[i] with zero latency; with BYPASS=1 and an enabled write to raddr[i] in the same cycle, rdata[i] SHALL show that write's data instead, using the REQ-021 priority.
REQ-024 rbusy[i] SHALL equal busy[raddr[i]]; with BYPASS=1 it SHALL be 0 if an enabled write targets raddr[i] in the same cycle.
REQ-025 alloc_ok SHALL be 1 when busy[alloc_addr]=0 or alloc_addr=0 (ZERO_R0=1); it is independent of alloc_en and same-cycle writes.
REQ-026 alloc_en=1 with alloc_ok=1 SHALL set busy[alloc_addr] at the next edge (no effect for address 0 with ZERO_R0=1); alloc_en with alloc_ok=0 SHALL be ignored.
REQ-027 Any enabled write, not only the winning port, SHALL clear busy[waddr] at the next edge.
REQ-028 When an accepted allocation and a write target the same address in one cycle, the set SHALL win and busy remains 1.
REQ-029 busy_cnt SHALL track the popcount of the busy vector exactly, updated in the same edge as the vector; it never exceeds NREG-1 with ZERO_R0=1, or NREG otherwise.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all registers, all busy bits and busy_cnt to 0, regardless of clk.
REQ-031 During reset rdata SHALL read 0, rbusy 0 and alloc_ok 1; writes and allocations SHALL be ignored until the first rising edge after rst_n rises.

Verification
REQ-032 Reset, then we[0]=1, waddr=3, wdata=0xDEADBEEF; next cycle raddr[0]=3 -> rdata 0xDEADBEEF, rbusy 0.
REQ-033 Same cycle we[0]=1 (addr 5, 0x11) and we[1]=1 (addr 5, 0x22) -> reg5=0x22; with BYPASS=1, same-cycle raddr=5 -> rdata 0x22.
REQ-034 Write 0x55 to addr 0 -> rdata for addr 0 = 0, busy_cnt 0.
REQ-035 Alloc 7 -> busy_cnt 1, rbusy 1, alloc_ok 0 for 7; second alloc 7 ignored, busy_cnt stays 1; write addr 7 -> rbusy 0 in the same cycle (BYPASS=1), busy_cnt 0 next cycle.
REQ-036 Alloc 9 while writing 9 -> busy[9]=1 after the edge; assert rst_n=0 mid-cycle -> all registers, rdata, and busy_cnt 0 immediately.
